// File: rtl/card_grid_pkg.sv
// Card-grid geometry shared by the selection controller and the display.
package card_grid_pkg;

    localparam int unsigned GRID_ROWS = 8;
    localparam int unsigned GRID_COLS = 18;
    localparam int unsigned NUM_CELLS = GRID_ROWS * GRID_COLS;
    localparam int unsigned CELL_W    = 32;
    localparam int unsigned X0        = 32;
    localparam int unsigned X_END     = X0 + GRID_COLS * CELL_W;
    localparam int unsigned CELL_H    = 46;
    localparam int unsigned CARD_BITS = 6;

    localparam logic [CARD_BITS-1:0] CARD_EMPTY = 6'd0;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        CHECK
    } sel_state_t;

    // Rows 0..5 sit on a 55 px pitch; rows 6 and 7 are offset by the display layout.
    function automatic logic [9:0] row_start(input logic [2:0] r);
        case (r)
            3'd0: return 10'd19;
            3'd1: return 10'd74;
            3'd2: return 10'd129;
            3'd3: return 10'd184;
            3'd4: return 10'd239;
            3'd5: return 10'd294;
            3'd6: return 10'd360;
            3'd7: return 10'd415;
        endcase
    endfunction

endpackage

// File: rtl/grid_hit_decode.sv
// Combinational pixel position to card-grid cell decode.
module grid_hit_decode
    import card_grid_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       col_valid,
    output logic       row_valid,
    output logic [7:0] idx
);

    logic [9:0] x_off;
    logic [4:0] col;
    logic [2:0] row;
    logic [7:0] row_w;

    // Column from 32 px slices, row by searching the start table, idx = row*18 + col.
    always_comb begin
        x_off     = x - 10'(X0);
        col_valid = (x >= 10'(X0)) && (x < 10'(X_END));
        col       = x_off[9:5];
        row_valid = 1'b0;
        row       = '0;
        for (int unsigned r = 0; r < GRID_ROWS; r++) begin
            if ((y >= row_start(3'(r))) && (y < row_start(3'(r)) + 10'(CELL_H))) begin
                row_valid = 1'b1;
                row       = 3'(r);
            end
        end
        row_w = {5'd0, row};
        idx   = (row_w << 4) + (row_w << 1) + {3'd0, col};
    end

endmodule

// File: rtl/card_select_ctrl.sv
// Mouse-driven card selection: toggles sel_card bits on left-click edges.
module card_select_ctrl
    import card_grid_pkg::*;
#(
    parameter int unsigned MAX_SEL = 144
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic         en,
    input  logic [9:0]   mouse_x,
    input  logic [9:0]   mouse_y,
    input  logic         l_click,
    input  logic         clear_sel,
    input  logic [863:0] map,
    output logic [143:0] sel_card,
    output logic [7:0]   sel_cnt,
    output logic         hover_valid,
    output logic [7:0]   hover_idx,
    output logic         sel_change
);

    sel_state_t state;

    logic                 click_q;
    logic                 click_edge;
    logic [9:0]           lat_x;
    logic [9:0]           lat_y;
    logic                 c_row_valid;
    logic                 c_col_valid;
    logic [7:0]           c_idx;
    logic                 dec_row_valid;
    logic                 dec_col_valid;
    logic [7:0]           dec_idx;
    logic                 h_row_valid;
    logic                 h_col_valid;
    logic [7:0]           h_idx;
    logic [CARD_BITS-1:0] cell_code;
    logic                 cell_sel;
    logic                 commit;

    grid_hit_decode u_click_decode (
        .x         (lat_x),
        .y         (lat_y),
        .col_valid (c_col_valid),
        .row_valid (c_row_valid),
        .idx       (c_idx)
    );

    grid_hit_decode u_hover_decode (
        .x         (mouse_x),
        .y         (mouse_y),
        .col_valid (h_col_valid),
        .row_valid (h_row_valid),
        .idx       (h_idx)
    );

    // Click edge and commit qualification for the cell held in the decode registers.
    always_comb begin
        click_edge = l_click & ~click_q;
        cell_code  = map[int'(dec_idx) * CARD_BITS +: CARD_BITS];
        cell_sel   = sel_card[dec_idx];
        commit     = dec_row_valid && dec_col_valid && (cell_code != CARD_EMPTY) &&
                     (cell_sel || (32'(sel_cnt) < MAX_SEL));
    end

    // Selection FSM: latch click position, decode, then toggle; clear_sel overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            click_q       <= 1'b0;
            lat_x         <= '0;
            lat_y         <= '0;
            dec_row_valid <= 1'b0;
            dec_col_valid <= 1'b0;
            dec_idx       <= '0;
            sel_card      <= '0;
            sel_cnt       <= '0;
            sel_change    <= 1'b0;
        end else if (interboard_rst) begin
            state         <= IDLE;
            click_q       <= 1'b0;
            lat_x         <= '0;
            lat_y         <= '0;
            dec_row_valid <= 1'b0;
            dec_col_valid <= 1'b0;
            dec_idx       <= '0;
            sel_card      <= '0;
            sel_cnt       <= '0;
            sel_change    <= 1'b0;
        end else begin
            click_q    <= l_click;
            sel_change <= 1'b0;
            if (clear_sel) begin
                sel_card   <= '0;
                sel_cnt    <= '0;
                sel_change <= (sel_cnt != 8'd0);
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (click_edge && en) begin
                            lat_x <= mouse_x;
                            lat_y <= mouse_y;
                            state <= DECODE;
                        end
                    end
                    DECODE: begin
                        dec_row_valid <= c_row_valid;
                        dec_col_valid <= c_col_valid;
                        dec_idx       <= c_idx;
                        state         <= CHECK;
                    end
                    CHECK: begin
                        if (commit) begin
                            sel_card[dec_idx] <= ~cell_sel;
                            sel_cnt           <= cell_sel ? (sel_cnt - 8'd1) : (sel_cnt + 8'd1);
                            sel_change        <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Hover path: register the live mouse decode every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hover_valid <= 1'b0;
            hover_idx   <= '0;
        end else if (interboard_rst) begin
            hover_valid <= 1'b0;
            hover_idx   <= '0;
        end else begin
            hover_valid <= h_row_valid & h_col_valid;
            hover_idx   <= h_idx;
        end
    end

endmodule
